// File: rtl/uart_event_reporter.sv
// Game event reporter: queues {code, score} events in a small FIFO and streams
// each one as the 7-byte ASCII line "C:HHHH\n" through the uart core handshake.
module uart_event_reporter #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              event_valid,
  output logic              event_ready,
  input  logic [3:0]        event_code,
  input  logic [15:0]       event_score,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  input  logic              is_transmitting,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]     FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0]     ZERO_COUNT = {CW{1'b0}};
  localparam logic [2:0]        LAST_INDEX = 3'd6;
  localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_SEND       = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] code_char(input logic [3:0] code);
    logic [7:0] c;
    case (code)
      4'd0:    c = 8'h4E;
      4'd1:    c = 8'h41;
      4'd2:    c = 8'h44;
      4'd3:    c = 8'h53;
      4'd4:    c = 8'h57;
      4'd5:    c = 8'h43;
      4'd6:    c = 8'h58;
      4'd7:    c = 8'h5A;
      4'd8:    c = 8'h42;
      default: c = 8'h3F;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else begin
      c = 8'h37 + {4'h0, nib};
    end
    return c;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [3:0]  code,
                                          input logic [15:0] score,
                                          input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = code_char(code);
      3'd1:    b = 8'h3A;
      3'd2:    b = hex_char(score[15:12]);
      3'd3:    b = hex_char(score[11:8]);
      3'd4:    b = hex_char(score[7:4]);
      3'd5:    b = hex_char(score[3:0]);
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  state_t            state_r, state_s;
  logic [19:0]       mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r, count_s;
  logic [3:0]        msg_code_r;
  logic [15:0]       msg_score_r;
  logic [2:0]        index_r, index_s;
  logic              transmit_r, strobe_s;
  logic [7:0]        tx_byte_r;
  logic              busy_r, ready_r;
  logic [DROP_W-1:0] drop_r;
  logic              push_s, pop_s, drop_s;

  // A full FIFO refuses even during LOAD: acceptance depends on the registered count only.
  assign push_s = event_valid & ready_r;
  assign drop_s = event_valid & ~ready_r;
  assign pop_s  = (state_r == ST_LOAD);

  assign event_ready = ready_r;
  assign transmit    = transmit_r;
  assign tx_byte     = tx_byte_r;
  assign busy        = busy_r;
  assign drop_cnt    = drop_r;

  // Next FIFO occupancy from simultaneous push/pop.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // Message FSM next-state, byte index and strobe decision.
  always_comb begin
    state_s  = state_r;
    index_s  = index_r;
    strobe_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != ZERO_COUNT) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        index_s = 3'd0;
        state_s = ST_SEND;
      end
      ST_SEND: begin
        if (!is_transmitting) begin
          strobe_s = 1'b1;
          state_s  = ST_WAIT_START;
        end else begin
          state_s  = ST_SEND;
        end
      end
      ST_WAIT_START: begin
        if (is_transmitting) begin
          state_s = ST_WAIT_DONE;
        end else begin
          state_s = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        if (is_transmitting) begin
          state_s = ST_WAIT_DONE;
        end else if (index_r != LAST_INDEX) begin
          index_s = index_r + 3'd1;
          state_s = ST_SEND;
        end else if (count_r != ZERO_COUNT) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 20'h00000;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {event_code, event_score};
    end
  end

  // FIFO pointers, occupancy and the saturating drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_COUNT;
      drop_r   <= {DROP_W{1'b0}};
    end else begin
      count_r <= count_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (drop_s && (drop_r != DROP_MAX)) begin
        drop_r <= drop_r + DROP_W'(1);
      end
    end
  end

  // FSM state, message latch and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      index_r     <= 3'd0;
      msg_code_r  <= 4'h0;
      msg_score_r <= 16'h0000;
      transmit_r  <= 1'b0;
      tx_byte_r   <= 8'h00;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      index_r    <= index_s;
      transmit_r <= strobe_s;
      busy_r     <= (state_s != ST_IDLE) || (count_s != ZERO_COUNT);
      ready_r    <= (count_s != FULL_COUNT);
      if (pop_s) begin
        {msg_code_r, msg_score_r} <= mem_r[rd_ptr_r];
      end
      if (strobe_s) begin
        tx_byte_r <= msg_byte(msg_code_r, msg_score_r, index_r);
      end
    end
  end

endmodule

// File: tb/tb_uart_event_reporter.sv
// Self-checking bench for uart_event_reporter: fixed message vectors, random
// traffic against a queue-based line model, and the overflow/reset corner cases.
module tb_uart_event_reporter;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              event_valid;
  logic              event_ready;
  logic [3:0]        event_code;
  logic [15:0]       event_score;
  logic              transmit;
  logic [7:0]        tx_byte;
  logic              is_transmitting;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  int unsigned uart_cnt   = 0;
  int unsigned busy_len   = 10;
  logic        hold_busy  = 1'b0;
  logic        prev_tx    = 1'b0;
  int          consec_err = 0;
  logic [7:0]  cap_q[$];
  logic [7:0]  exp_q[$];
  int          cap_base = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] score;
    logic [55:0] bytes;
  } vec_t;
  vec_t vecs[10];

  uart_event_reporter #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset_n(reset_n), .event_valid(event_valid), .event_ready(event_ready),
    .event_code(event_code), .event_score(event_score), .transmit(transmit),
    .tx_byte(tx_byte), .is_transmitting(is_transmitting), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  assign is_transmitting = (uart_cnt != 0);

  // uart core model: busy from the cycle after a strobe for busy_len cycles,
  // or indefinitely while hold_busy is set.
  always @(posedge clk) begin
    prev_tx <= transmit;
    if (transmit) begin
      cap_q.push_back(tx_byte);
      if (prev_tx) consec_err <= consec_err + 1;
      uart_cnt <= busy_len;
    end else if (uart_cnt > 1 || (uart_cnt == 1 && !hold_busy)) begin
      uart_cnt <= uart_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [3:0] code, input logic [15:0] score,
                                            input int idx);
    string hexs  = "0123456789ABCDEF";
    string chars = "NADSWCXZB";
    logic [15:0] sh;
    if (idx == 0) return (code <= 4'd8) ? chars[code] : 8'h3F;
    if (idx == 1) return 8'h3A;
    if (idx == 6) return 8'h0A;
    sh = score >> (4 * (5 - idx));
    return hexs[sh[3:0]];
  endfunction

  task automatic add_exp(input logic [3:0] code, input logic [15:0] score);
    for (int i = 0; i < 7; i++) exp_q.push_back(model_byte(code, score, i));
  endtask

  task automatic offer(input logic [3:0] code, input logic [15:0] score, output logic rdy);
    event_valid = 1'b1;
    event_code  = code;
    event_score = score;
    rdy = event_ready;
    @(negedge clk);
    event_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_caps(input string name, input int num, input int budget);
    int n = 0;
    while ((cap_q.size() - cap_base) < num && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, 32'(cap_q.size() - cap_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (cap_base + i < cap_q.size())
        check($sformatf("%s[%0d]", name, i), 32'(cap_q[cap_base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    event_valid = 1'b0;
    hold_busy   = 1'b0;
    reset_n     = 1'b0;
    repeat (20) @(negedge clk);
    reset_n  = 1'b1;
    cap_base = cap_q.size();
    exp_q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic        rdy;
    logic [3:0]  code;
    logic [15:0] score;
    int          rem, outstanding, n_before;

    vecs[0] = '{4'd1,  16'h12AF, 56'h41_3A_31_32_41_46_0A};
    vecs[1] = '{4'd0,  16'h0000, 56'h4E_3A_30_30_30_30_0A};
    vecs[2] = '{4'd8,  16'h0000, 56'h42_3A_30_30_30_30_0A};
    vecs[3] = '{4'd15, 16'h0000, 56'h3F_3A_30_30_30_30_0A};
    vecs[4] = '{4'd3,  16'hBEEF, 56'h53_3A_42_45_45_46_0A};
    vecs[5] = '{4'd6,  16'h09A5, 56'h58_3A_30_39_41_35_0A};
    vecs[6] = '{4'd2,  16'hFFFF, 56'h44_3A_46_46_46_46_0A};
    vecs[7] = '{4'd4,  16'h3C70, 56'h57_3A_33_43_37_30_0A};
    vecs[8] = '{4'd5,  16'h0001, 56'h43_3A_30_30_30_31_0A};
    vecs[9] = '{4'd7,  16'h8000, 56'h5A_3A_38_30_30_30_0A};

    reset_n = 1'b0; event_valid = 1'b0; event_code = 4'h0; event_score = 16'h0000;
    repeat (5) @(negedge clk);
    check("rst_transmit", 32'(transmit), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ready", 32'(event_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Fixed single-message vectors
    busy_len = 10;
    for (int i = 0; i < 10; i++) begin
      cap_base = cap_q.size();
      offer(vecs[i].code, vecs[i].score, rdy);
      check("vec_ready", 32'(rdy), 32'd1);
      wait_idle("vec_idle", 1000);
      check($sformatf("vec%0d_count", i), 32'(cap_q.size() - cap_base), 32'd7);
      for (int b = 0; b < 7; b++) begin
        if (cap_base + b < cap_q.size())
          check($sformatf("vec%0d_byte%0d", i, b), 32'(cap_q[cap_base + b]),
                32'(vecs[i].bytes[55 - 8 * b -: 8]));
      end
      check("vec_tx_hold", 32'(tx_byte), 32'h0A);
      check("vec_transmit_low", 32'(transmit), 32'd0);
    end

    // Random traffic, never offered beyond what the model knows fits
    cap_base = cap_q.size();
    exp_q.delete();
    for (int c = 0; c < 800; c++) begin
      busy_len    = $urandom_range(1, 12);
      rem         = exp_q.size() - (cap_q.size() - cap_base);
      outstanding = (rem + 6) / 7;
      if (outstanding < DEPTH && $urandom_range(0, 2) == 0) begin
        code  = 4'($urandom_range(0, 15));
        score = 16'($urandom);
        event_valid = 1'b1; event_code = code; event_score = score;
        check("rand_ready", 32'(event_ready), 32'd1);
        add_exp(code, score);
      end else begin
        event_valid = 1'b0;
      end
      @(negedge clk);
    end
    event_valid = 1'b0;
    wait_idle("rand_idle", 5000);
    compare_stream("rand_byte");
    check("rand_drop", 32'(drop_cnt), 32'd0);

    // Overflow with the uart held busy, then drop counter saturation
    do_reset();
    busy_len  = 10;
    hold_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(4'(i % 9), 16'hA000 + 16'(i), rdy);
      check($sformatf("burst_ready%0d", i), 32'(rdy), 32'(i < 9));
      if (i < 9) add_exp(4'(i % 9), 16'hA000 + 16'(i));
    end
    repeat (5) @(negedge clk);
    check("burst_strobes", 32'(cap_q.size() - cap_base), 32'd1);
    check("burst_drop", 32'(drop_cnt), 32'd1);
    check("burst_ready_low", 32'(event_ready), 32'd0);
    check("burst_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 300; i++) offer(4'd3, 16'(i), rdy);
    check("sat_drop", 32'(drop_cnt), 32'd255);
    for (int i = 0; i < 5; i++) offer(4'd4, 16'(i), rdy);
    check("sat_hold", 32'(drop_cnt), 32'd255);
    hold_busy = 1'b0;
    wait_idle("burst_idle", 20000);
    compare_stream("burst_byte");
    check("burst_drop_final", 32'(drop_cnt), 32'd255);

    // Full FIFO while the last byte is in flight; offer exactly in the LOAD cycle
    do_reset();
    busy_len = 10;
    offer(4'd6, 16'h0F0F, rdy);
    add_exp(4'd6, 16'h0F0F);
    wait_caps("last_byte", 7, 500);
    hold_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(4'(i + 1), 16'hB000 + 16'(i), rdy);
      check("fill_ready", 32'(rdy), 32'd1);
      add_exp(4'(i + 1), 16'hB000 + 16'(i));
    end
    repeat (3) @(negedge clk);
    check("full_ready", 32'(event_ready), 32'd0);
    hold_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("load_ready", 32'(event_ready), 32'd0);
    offer(4'd9, 16'hDEAD, rdy);
    check("load_drop", 32'(drop_cnt), 32'd1);
    check("post_load_ready", 32'(event_ready), 32'd1);
    offer(4'd2, 16'hC0DE, rdy);
    check("post_load_accept", 32'(rdy), 32'd1);
    add_exp(4'd2, 16'hC0DE);
    check("refull_ready", 32'(event_ready), 32'd0);
    wait_idle("load_idle", 20000);
    compare_stream("load_byte");

    // Asynchronous reset in the middle of a message
    cap_base = cap_q.size();
    exp_q.delete();
    busy_len = 4;
    offer(4'd5, 16'h0ABC, rdy);
    wait_caps("three_bytes", 3, 500);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_transmit", 32'(transmit), 32'd0);
    check("arst_tx_byte", 32'(tx_byte), 32'h00);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    check("arst_ready", 32'(event_ready), 32'd1);
    @(negedge clk);
    reset_n  = 1'b1;
    n_before = cap_q.size();
    repeat (40) @(negedge clk);
    check("no_resume", 32'(cap_q.size()), 32'(n_before));
    check("no_resume_busy", 32'(busy), 32'd0);
    cap_base = cap_q.size();
    offer(4'd8, 16'h7777, rdy);
    add_exp(4'd8, 16'h7777);
    wait_idle("post_reset_idle", 1000);
    compare_stream("post_reset_byte");

    check("no_back_to_back_strobe", 32'(consec_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
